spi_flash_seq: RTL and testbench
================================

Name: spi_flash_seq

Overview:
Command sequencer in front of the SPI flash master. It turns single-cycle host requests (read, page program, sector erase, read status) into the flash command sequences the master executes: write-enable (WREN), then the operation, then status-register (RDSR) polling until the flash clears its write-in-progress (WIP) bit. It drives the master's command/address/data/commtype/validflag interface and collects master replies into one response per request.

Parameters:
TMO_CYC, 1024, max clk cycles per master transaction, from validflag assertion to done
POLL_MAX, 65535, max RDSR polls before an erase/program times out
POLL_GAP, 16, idle clk cycles between consecutive RDSR polls

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
req_valid  in  1  host request strobe
req_op  in  2  00 read word, 01 page program word, 10 sector erase, 11 read status
req_addr  in  32  flash byte address (low 24 bits used)
req_wdata  in  32  program data
req_ready  out  1  idle, request accepted when req_valid & req_ready
rsp_valid  out  1  one-cycle response pulse
rsp_data  out  32  read data / status byte zero-extended / 0
rsp_err  out  1  timeout flag, valid with rsp_valid
m_data_in  out  32  master data_in
m_address  out  32  master address
m_command  out  8  master command opcode
m_commtype  out  3  master command type
m_nmiso_bits  out  7  master MISO bit count
m_validflag  out  1  master request flag
m_data_out  in  32  master read data
m_validflag_out  in  1  master reply pulse, sclk domain
m_tready  in  1  master idle, sclk domain

Behaviour:
- Reset, all values held while rst=0: req_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, m_validflag=0, m_commtype=3'b111, m_command/m_address/m_data_in=0, m_nmiso_bits=0, FSM=IDLE.
- m_tready and m_validflag_out each pass through a 2-flop synchronizer. A rising edge of the synced validflag_out sets a sticky reply_seen bit, cleared at each transaction start.
- Transaction primitive XFER(cmd, ctype, nbits, expect):
  - ISSUE: drive the fields and set m_validflag=1; clear reply_seen; load the timeout counter with TMO_CYC.
  - ACCEPT: wait for synced tready=0, then drop m_validflag to 0.
  - DONE_WAIT: wait for synced tready=1 and, if expect=1, reply_seen=1. On completion, capture m_data_out.
  - Fields stay stable from ISSUE until completion.
  - m_validflag is high for at least 2 clk cycles, so the master registers it.
  - The timeout counter decrements every cycle in ISSUE/ACCEPT/DONE_WAIT; reaching 0 aborts to DONE with rsp_err=1.
- Op encodings (cmd, ctype, nbits):
  - READ: 0x03, 010, 32.
  - RDSR: 0x05, 001, 8.
  - WREN: 0x06, 000, 0.
  - PP: 0x02, 100, 0 (address + data).
  - SE: 0x20, 101, 0.
- FSM states: IDLE, WREN, OP, POLL, GAP, DONE.
  - IDLE: req_ready=1. On accept, latch op/addr/wdata and set req_ready=0.
    - op 00 -> OP (READ). op 11 -> OP (RDSR).
    - op 01/10 -> WREN.
  - WREN: XFER(WREN) -> OP (PP or SE).
  - OP: for READ/RDSR, XFER with expect=1 -> DONE; rsp_data = captured word, status masked to [7:0].
    - For PP/SE, XFER, then load poll_cnt=POLL_MAX -> POLL.
  - POLL: XFER(RDSR). If captured bit0 (WIP)=0 -> DONE with rsp_data=0. Else decrement poll_cnt -> GAP; if poll_cnt was already 0 -> DONE with rsp_err=1.
  - GAP: wait POLL_GAP cycles -> POLL.
  - DONE: rsp_valid=1 for one cycle -> IDLE; req_ready returns to 1 on the following cycle.
- req_valid while req_ready=0 is ignored; no queueing.
- After a timeout, m_validflag is forced to 0 and the block does not re-issue commands; it does not wait for the master.
- Reset mid-sequence abandons the sequence immediately. Outputs go to reset values, no response is generated, and the host re-issues.
- Widths: poll_cnt is 16-bit. The timeout counter is $clog2(TMO_CYC+1) bits. Counters saturate at 0; there is no wrap.

Test Plan:
- READ, req_addr=0x000100, master model returns 0xDEADBEEF -> one transaction with m_command=0x03, m_commtype=010, m_nmiso_bits=32, m_address=0x100; rsp_valid with rsp_data=0xDEADBEEF, rsp_err=0.
- Program addr 0x2000, data 0x12345678, status returns 0x03, 0x03, 0x00 -> WREN (0x06/000), then PP (0x02/100, m_data_in=0x12345678), then exactly 3 RDSR polls; rsp_data=0, rsp_err=0.
- Erase with POLL_MAX=3, status stuck at 0x01 -> WREN, SE (0x20/101), 4 polls, then rsp_err=1; req_ready returns to 1.
- Master never lowers tready, TMO_CYC=1024 -> rsp_err=1 at cycle 1024±3 after ISSUE; m_validflag=0 afterwards.
- req_valid pulsed while busy -> ignored; exactly one rsp_valid per accepted request; m_validflag high ≥2 cycles per transaction.
- Reset asserted during POLL -> all outputs at reset values while rst=0; no rsp_valid; a new READ afterwards completes normally.

Source files
------------

// File: rtl/spi_flash_seq.sv
// spi_flash_seq: command sequencer in front of an SPI flash master.
// Turns single-cycle host requests into master transaction sequences:
//   READ / RDSR : one transaction, reply data returned to the host
//   PP / SE     : WREN, the operation, then RDSR polling until WIP clears
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   req_*             host request (valid/ready handshake)
//   rsp_*             one-cycle response pulse with data and timeout flag
//   m_*               SPI master request fields and reply (sclk-domain replies)
module spi_flash_seq #(
  parameter int unsigned TMO_CYC  = 1024,
  parameter int unsigned POLL_MAX = 65535,
  parameter int unsigned POLL_GAP = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [31:0] m_data_in,
  output logic [31:0] m_address,
  output logic [7:0]  m_command,
  output logic [2:0]  m_commtype,
  output logic [6:0]  m_nmiso_bits,
  output logic        m_validflag,
  input  logic [31:0] m_data_out,
  input  logic        m_validflag_out,
  input  logic        m_tready
);

  localparam int unsigned TW = $clog2(TMO_CYC + 1);
  localparam int unsigned GW = (POLL_GAP < 1) ? 1 : $clog2(POLL_GAP + 1);
  localparam int unsigned PW = 16;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WREN = 3'd1;
  localparam logic [2:0] S_OP   = 3'd2;
  localparam logic [2:0] S_POLL = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam logic [1:0] PH_ISSUE  = 2'd0;
  localparam logic [1:0] PH_ACCEPT = 2'd1;
  localparam logic [1:0] PH_WAIT   = 2'd2;

  localparam logic [1:0] OP_READ = 2'b00;
  localparam logic [1:0] OP_PP   = 2'b01;
  localparam logic [1:0] OP_SE   = 2'b10;
  localparam logic [1:0] OP_RDSR = 2'b11;

  // transaction selector for the issue logic
  localparam logic [2:0] X_WREN = 3'd0;
  localparam logic [2:0] X_READ = 3'd1;
  localparam logic [2:0] X_RDSR = 3'd2;
  localparam logic [2:0] X_PP   = 3'd3;
  localparam logic [2:0] X_SE   = 3'd4;

  // synchronizers for the sclk-domain master status
  logic [1:0] tready_sync;
  logic [1:0] vfo_sync;
  logic       vfo_last;
  logic       tready_s;
  logic       vfo_rise;

  assign tready_s = tready_sync[1];
  assign vfo_rise = vfo_sync[1] & ~vfo_last;

  // master assumed idle out of reset so a first request is not dropped early
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tready_sync <= 2'b11;
      vfo_sync    <= 2'b00;
      vfo_last    <= 1'b0;
    end else begin
      tready_sync <= {tready_sync[0], m_tready};
      vfo_sync    <= {vfo_sync[0], m_validflag_out};
      vfo_last    <= vfo_sync[1];
    end
  end

  logic addr_hi_unused;
  assign addr_hi_unused = ^req_addr[31:24];

  logic [2:0]    state, state_d;
  logic [1:0]    ph, ph_d;
  logic [1:0]    op_q, op_d;
  logic [23:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          expect_q, expect_d;
  logic [TW-1:0] tmo, tmo_d;
  logic [PW-1:0] poll_cnt, poll_d;
  logic [GW-1:0] gap_cnt, gap_d;
  logic          reply_seen, reply_d;

  logic          req_ready_d, rsp_valid_d, rsp_err_d, vf_d;
  logic [31:0]   rsp_data_d, addr_o_d, din_d;
  logic [7:0]    cmd_d;
  logic [2:0]    ctype_d;
  logic [6:0]    nbits_d;

  logic          in_xfer, xfer_done, xfer_tmo, start;
  logic [2:0]    xsel;

  assign in_xfer = (state == S_WREN) || (state == S_OP) || (state == S_POLL);

  // next-state and next-output logic
  always_comb begin
    state_d     = state;
    ph_d        = ph;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    expect_d    = expect_q;
    tmo_d       = tmo;
    poll_d      = poll_cnt;
    gap_d       = gap_cnt;
    reply_d     = reply_seen | vfo_rise;
    req_ready_d = req_ready;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data;
    rsp_err_d   = rsp_err;
    vf_d        = m_validflag;
    cmd_d       = m_command;
    ctype_d     = m_commtype;
    nbits_d     = m_nmiso_bits;
    addr_o_d    = m_address;
    din_d       = m_data_in;
    xfer_done   = 1'b0;
    xfer_tmo    = 1'b0;
    start       = 1'b0;
    xsel        = X_WREN;

    // transaction engine shared by WREN/OP/POLL
    if (in_xfer) begin
      case (ph)
        PH_ISSUE:  ph_d = PH_ACCEPT;
        PH_ACCEPT: begin
          if (!tready_s) begin
            vf_d = 1'b0;
            ph_d = PH_WAIT;
          end
        end
        PH_WAIT: begin
          if (tready_s && (!expect_q || reply_seen)) xfer_done = 1'b1;
        end
        default: ph_d = PH_ISSUE;
      endcase
      if (!xfer_done) begin
        if (tmo <= TW'(1)) begin
          tmo_d    = '0;
          xfer_tmo = 1'b1;
        end else begin
          tmo_d = tmo - TW'(1);
        end
      end
    end

    case (state)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          op_d        = req_op;
          addr_d      = req_addr[23:0];
          wdata_d     = req_wdata;
          req_ready_d = 1'b0;
          start       = 1'b1;
          case (req_op)
            OP_READ: begin state_d = S_OP;   xsel = X_READ; end
            OP_RDSR: begin state_d = S_OP;   xsel = X_RDSR; end
            default: begin state_d = S_WREN; xsel = X_WREN; end
          endcase
        end
      end
      S_WREN: begin
        if (xfer_done) begin
          state_d = S_OP;
          start   = 1'b1;
          xsel    = (op_q == OP_PP) ? X_PP : X_SE;
        end
      end
      S_OP: begin
        if (xfer_done) begin
          if (op_q == OP_READ) begin
            state_d    = S_DONE;
            rsp_data_d = m_data_out;
          end else if (op_q == OP_RDSR) begin
            state_d    = S_DONE;
            rsp_data_d = {24'h000000, m_data_out[7:0]};
          end else begin
            poll_d  = PW'(POLL_MAX);
            state_d = S_POLL;
            start   = 1'b1;
            xsel    = X_RDSR;
          end
        end
      end
      S_POLL: begin
        if (xfer_done) begin
          rsp_data_d = '0;
          if (!m_data_out[0]) begin
            state_d = S_DONE;
          end else if (poll_cnt == '0) begin
            state_d   = S_DONE;
            rsp_err_d = 1'b1;
          end else begin
            poll_d  = poll_cnt - PW'(1);
            gap_d   = GW'(POLL_GAP);
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt <= GW'(1)) begin
          gap_d   = '0;
          state_d = S_POLL;
          start   = 1'b1;
          xsel    = X_RDSR;
        end else begin
          gap_d = gap_cnt - GW'(1);
        end
      end
      S_DONE: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
        rsp_err_d   = 1'b0;
      end
      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end
    endcase

    // a master that stops responding ends the request; nothing is re-issued
    if (xfer_tmo) begin
      state_d    = S_DONE;
      rsp_err_d  = 1'b1;
      rsp_data_d = '0;
      vf_d       = 1'b0;
    end

    // fields are loaded once here and held until the transaction completes
    if (start) begin
      vf_d     = 1'b1;
      ph_d     = PH_ISSUE;
      tmo_d    = TW'(TMO_CYC);
      reply_d  = 1'b0;
      addr_o_d = {8'h00, addr_d};
      din_d    = wdata_d;
      case (xsel)
        X_READ:  begin cmd_d = 8'h03; ctype_d = 3'b010; nbits_d = 7'd32; expect_d = 1'b1; end
        X_RDSR:  begin cmd_d = 8'h05; ctype_d = 3'b001; nbits_d = 7'd8;  expect_d = 1'b1; end
        X_PP:    begin cmd_d = 8'h02; ctype_d = 3'b100; nbits_d = 7'd0;  expect_d = 1'b0; end
        X_SE:    begin cmd_d = 8'h20; ctype_d = 3'b101; nbits_d = 7'd0;  expect_d = 1'b0; end
        default: begin cmd_d = 8'h06; ctype_d = 3'b000; nbits_d = 7'd0;  expect_d = 1'b0; end
      endcase
    end

    if ((state_d == S_DONE) && (state != S_DONE)) rsp_valid_d = 1'b1;
  end

  // state and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      ph           <= PH_ISSUE;
      op_q         <= OP_READ;
      addr_q       <= '0;
      wdata_q      <= '0;
      expect_q     <= 1'b0;
      tmo          <= '0;
      poll_cnt     <= '0;
      gap_cnt      <= '0;
      reply_seen   <= 1'b0;
      req_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_err      <= 1'b0;
      m_validflag  <= 1'b0;
      m_command    <= '0;
      m_commtype   <= 3'b111;
      m_nmiso_bits <= '0;
      m_address    <= '0;
      m_data_in    <= '0;
    end else begin
      state        <= state_d;
      ph           <= ph_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      expect_q     <= expect_d;
      tmo          <= tmo_d;
      poll_cnt     <= poll_d;
      gap_cnt      <= gap_d;
      reply_seen   <= reply_d;
      req_ready    <= req_ready_d;
      rsp_valid    <= rsp_valid_d;
      rsp_data     <= rsp_data_d;
      rsp_err      <= rsp_err_d;
      m_validflag  <= vf_d;
      m_command    <= cmd_d;
      m_commtype   <= ctype_d;
      m_nmiso_bits <= nbits_d;
      m_address    <= addr_o_d;
      m_data_in    <= din_d;
    end
  end

endmodule

// File: tb/tb_spi_flash_seq.sv
// Scoreboard bench for spi_flash_seq with a behavioural SPI master model.
module tb_spi_flash_seq;

  localparam int unsigned TMO  = 1024;
  localparam int unsigned PMAX = 3;
  localparam int unsigned PGAP = 16;

  logic clk = 1'b0;
  logic sclk = 1'b0;
  logic rst = 1'b0;
  logic req_valid = 1'b0;
  logic [1:0] req_op = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_data, m_data_in, m_address;
  logic [7:0] m_command;
  logic [2:0] m_commtype;
  logic [6:0] m_nmiso_bits;
  logic m_validflag;
  logic [31:0] m_data_out;
  logic m_validflag_out, m_tready;

  always #5 clk = ~clk;
  always #7 sclk = ~sclk;

  spi_flash_seq #(.TMO_CYC(TMO), .POLL_MAX(PMAX), .POLL_GAP(PGAP)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .m_data_in(m_data_in), .m_address(m_address), .m_command(m_command),
    .m_commtype(m_commtype), .m_nmiso_bits(m_nmiso_bits), .m_validflag(m_validflag),
    .m_data_out(m_data_out), .m_validflag_out(m_validflag_out), .m_tready(m_tready)
  );

  typedef struct {
    logic [7:0]  cmd;
    logic [2:0]  ctype;
    logic [6:0]  nbits;
    logic [23:0] addr;
    logic [31:0] data;
    bit          chk_addr;
    bit          chk_data;
  } xfer_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  xfer_t xq[$];
  rsp_t  rq[$];
  logic [31:0] stat_q[$];
  logic [31:0] read_word = '0;
  bit never_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  int rsp_cnt = 0;
  int rdsr_seen = 0;
  int cyc = 0;
  int vf_len = 0;
  int vf_rise_cyc = 0;
  int rsp_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // response monitor
  always @(negedge clk) begin
    rsp_t e;
    if (rst && rsp_valid) begin
      rsp_cnt++;
      rsp_cyc = cyc;
      if (rq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp actual=%0h required=none", rsp_data);
      end else begin
        e = rq.pop_front();
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_err", rsp_err, e.err);
      end
    end
  end

  // validflag pulse width monitor
  always @(negedge clk) begin
    if (rst && m_validflag) begin
      if (vf_len == 0) vf_rise_cyc = cyc;
      vf_len++;
    end else begin
      if (vf_len != 0) chk("vf_width_ge2", 64'(vf_len >= 2), 64'd1);
      vf_len = 0;
    end
  end

  // SPI master model: records each request against the expected sequence
  initial begin
    xfer_t e;
    logic [7:0] cmd;
    logic [6:0] nb;
    m_tready = 1'b1;
    m_validflag_out = 1'b0;
    m_data_out = '0;
    forever begin
      @(posedge sclk);
      if (rst && m_validflag && !never_ready) begin
        cmd = m_command;
        nb  = m_nmiso_bits;
        if (xq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_xfer actual=%0h required=none", cmd);
        end else begin
          e = xq.pop_front();
          chk("x_cmd", cmd, e.cmd);
          chk("x_ctype", m_commtype, e.ctype);
          chk("x_nbits", nb, e.nbits);
          if (e.chk_addr) chk("x_addr", m_address, {8'h00, e.addr});
          if (e.chk_data) chk("x_data", m_data_in, e.data);
        end
        if (cmd == 8'h05) rdsr_seen++;
        m_tready = 1'b0;
        repeat (2) @(posedge sclk);
        if (cmd == 8'h03) m_data_out = read_word;
        else if (cmd == 8'h05) m_data_out = (stat_q.size() != 0) ? stat_q.pop_front() : 32'h0000_0001;
        if (nb != 0) begin
          m_validflag_out = 1'b1;
          @(posedge sclk);
          m_validflag_out = 1'b0;
        end
        for (int i = 0; i < 50 && m_validflag; i++) @(posedge sclk);
        chk("vf_dropped", m_validflag, 1'b0);
        @(posedge sclk);
        m_tready = 1'b1;
      end
    end
  end

  // reference model: expected transactions and response from the request rules
  task automatic plan(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wdata);
    xfer_t x;
    rsp_t r;
    x = '{cmd: 8'h00, ctype: 3'b000, nbits: 7'd0, addr: addr[23:0], data: wdata, chk_addr: 1'b0, chk_data: 1'b0};
    r = '{data: 32'h0, err: 1'b0};
    case (op)
      2'b00: begin
        x.cmd = 8'h03; x.ctype = 3'b010; x.nbits = 7'd32; x.chk_addr = 1'b1;
        xq.push_back(x);
        r.data = read_word;
      end
      2'b11: begin
        x.cmd = 8'h05; x.ctype = 3'b001; x.nbits = 7'd8;
        xq.push_back(x);
        r.data = {24'h0, stat_q[0][7:0]};
      end
      default: begin
        x.cmd = 8'h06; x.ctype = 3'b000; x.nbits = 7'd0;
        xq.push_back(x);
        x.chk_addr = 1'b1;
        if (op == 2'b01) begin x.cmd = 8'h02; x.ctype = 3'b100; x.chk_data = 1'b1; end
        else begin x.cmd = 8'h20; x.ctype = 3'b101; end
        xq.push_back(x);
        x = '{cmd: 8'h05, ctype: 3'b001, nbits: 7'd8, addr: 24'h0, data: 32'h0, chk_addr: 1'b0, chk_data: 1'b0};
        r.err = 1'b1;
        for (int i = 0; i <= int'(PMAX); i++) begin
          xq.push_back(x);
          if (i < stat_q.size() && stat_q[i][0] == 1'b0) begin
            r.err = 1'b0;
            break;
          end
        end
      end
    endcase
    rq.push_back(r);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!req_ready && n < 5000) begin @(posedge clk); #1; n++; end
    if (!req_ready) chk("ready_timeout", req_ready, 1'b1);
  endtask

  // drive one request, pulse stray req_valid while busy, then check the outcome
  task automatic issue_req(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wdata);
    int start_cnt;
    logic [31:0] junk;
    @(posedge clk); #1;
    wait_ready();
    start_cnt = rsp_cnt;
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 4000 && rsp_cnt == start_cnt; i++) begin
      if ($urandom_range(3) == 0 && !req_ready) begin
        junk = $urandom;
        req_valid = 1'b1; req_op = junk[1:0]; req_addr = junk;
      end else begin
        req_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rsp_count", 64'(rsp_cnt - start_cnt), 64'd1);
    chk("ready_back", req_ready, 1'b1);
    chk("xfers_left", 64'(xq.size()), 64'd0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_ctrl", {req_ready, rsp_valid, rsp_err, m_validflag, m_commtype, m_nmiso_bits},
        {1'b1, 1'b0, 1'b0, 1'b0, 3'b111, 7'd0});
    chk("rst_data", {rsp_data, m_data_in}, 64'd0);
    chk("rst_cmd_addr", {m_command, m_address}, 64'd0);
  endtask

  initial begin
    logic [31:0] v;
    logic [1:0] op;
    int k, lat, n;
    repeat (3) @(negedge clk);
    chk_reset_vals();
    rst = 1'b1;
    repeat (3) @(posedge clk);

    // directed: READ
    read_word = 32'hDEADBEEF;
    plan(2'b00, 32'h0000_0100, 32'h0);
    issue_req(2'b00, 32'h0000_0100, 32'h0);

    // directed: program with three polls
    stat_q.delete();
    stat_q.push_back(32'h03); stat_q.push_back(32'h03); stat_q.push_back(32'h00);
    plan(2'b01, 32'h0000_2000, 32'h12345678);
    issue_req(2'b01, 32'h0000_2000, 32'h12345678);

    // directed: erase with WIP stuck -> PMAX+1 polls then error
    stat_q.delete();
    for (int i = 0; i < 6; i++) stat_q.push_back(32'h01);
    plan(2'b10, 32'h0003_0000, 32'h0);
    issue_req(2'b10, 32'h0003_0000, 32'h0);

    // directed: read status, upper bits of master word must be masked
    stat_q.delete();
    stat_q.push_back(32'h5A5A_C3A4);
    plan(2'b11, 32'h0, 32'h0);
    issue_req(2'b11, 32'h0, 32'h0);

    // directed: master never accepts -> timeout
    stat_q.delete();
    never_ready = 1'b1;
    rq.push_back('{data: 32'h0, err: 1'b1});
    issue_req(2'b00, 32'h0000_0040, 32'h0);
    lat = rsp_cyc - vf_rise_cyc;
    checks++;
    if (lat < int'(TMO) - 3 || lat > int'(TMO) + 3) begin
      errors++;
      $display("FAIL tmo_latency actual=%0d required=%0d+-3", lat, TMO);
    end
    repeat (5) @(negedge clk);
    chk("vf_after_tmo", m_validflag, 1'b0);
    never_ready = 1'b0;

    // randomized requests
    for (int t = 0; t < 20; t++) begin
      v = $urandom; op = v[1:0];
      stat_q.delete();
      read_word = $urandom;
      if (op == 2'b11) begin
        stat_q.push_back($urandom);
      end else if (op != 2'b00) begin
        k = $urandom_range(0, 5);
        for (int i = 0; i < k; i++) begin v = $urandom; stat_q.push_back({v[31:1], 1'b1}); end
        v = $urandom; stat_q.push_back({v[31:1], 1'b0});
      end
      v = $urandom;
      plan(op, v, read_word ^ 32'hA5A5_0F0F);
      issue_req(op, v, read_word ^ 32'hA5A5_0F0F);
    end

    // reset during polling abandons the sequence
    stat_q.delete();
    for (int i = 0; i < 10; i++) stat_q.push_back(32'h01);
    plan(2'b01, 32'h0000_4000, 32'hCAFE_F00D);
    @(posedge clk); #1;
    wait_ready();
    k = rdsr_seen;
    req_valid = 1'b1; req_op = 2'b01; req_addr = 32'h4000; req_wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (rdsr_seen == k && n < 3000) begin @(posedge clk); #1; n++; end
    chk("poll_reached", 64'(rdsr_seen > k), 64'd1);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    rq.delete();
    xq.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_reset_vals();
    end
    n = 0;
    while (!m_tready && n < 200) begin @(posedge clk); n++; end
    #1;
    rst = 1'b1;
    k = rsp_cnt;
    repeat (3) @(posedge clk);
    chk("no_rsp_after_reset", 64'(rsp_cnt - k), 64'd0);
    stat_q.delete();
    read_word = 32'h0BAD_F00D;
    plan(2'b00, 32'h00AB_CDEF, 32'h0);
    issue_req(2'b00, 32'h00AB_CDEF, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

endmodule
